led_pwm_ctrl: RTL and testbench

LED_PWM_CTRL -- requirements
Module: led_pwm_ctrl

---
 rtl/led_ctrl_pkg.sv | 27 ++
 rtl/led_tick_gen.sv | 48 ++++
 rtl/led_pwm_ctrl.sv | 85 ++++++++
 tb/tb_led_pwm_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types for the LED PWM controller: LED mode encoding and command word layout.
package led_ctrl_pkg;

  localparam int NUM_LEDS = 4;
  localparam int LVL_W    = 4;

  localparam int CMD_W    = 8;
  localparam int IDX_LSB  = 6;
  localparam int IDX_W    = 2;
  localparam int MODE_LSB = 4;
  localparam int MODE_W   = 2;
  localparam int LVL_LSB  = 0;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_PWM   = 2'd2,
    MODE_BLINK = 2'd3
  } led_mode_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    led_mode_e        mode;
    logic [LVL_W-1:0] level;
  } led_cmd_t;

endpackage

// File: rtl/led_tick_gen.sv
// Timebase for the LED controller: prescaler tick, 16-step PWM counter,
// frame-end strobe and the blink half-period phase.
module led_tick_gen
  import led_ctrl_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             tick,
  output logic             frame_end,
  output logic [LVL_W-1:0] pwm_cnt,
  output logic             blink_phase
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] FRAME_MAX = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0] presc;
  logic [BW-1:0] frame_cnt;

  assign tick      = (presc == PRESC_MAX);
  assign frame_end = tick && (pwm_cnt == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc       <= '0;
      pwm_cnt     <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      if (frame_end) begin
        if (frame_cnt == FRAME_MAX) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/led_pwm_ctrl.sv
// Four-LED PWM/blink controller. One command slot is held pending and applied
// only at a PWM frame boundary so a running frame never glitches.
module led_pwm_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  input  logic [CMD_W-1:0]    cmd_data,
  output logic                cmd_ready,
  output logic [NUM_LEDS-1:0] led
);

  logic             tick;
  logic             frame_end;
  logic [LVL_W-1:0] pwm_cnt;
  logic             blink_phase;

  logic             pending;
  led_cmd_t         pend_cmd;
  led_mode_e        mode  [NUM_LEDS];
  logic [LVL_W-1:0] level [NUM_LEDS];
  logic [NUM_LEDS-1:0] lit;
  logic             accept;
  logic             apply;

  led_tick_gen #(
    .CLK_DIV      (CLK_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_tick_gen (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .frame_end   (frame_end),
    .pwm_cnt     (pwm_cnt),
    .blink_phase (blink_phase)
  );

  assign cmd_ready = !pending;
  assign accept    = cmd_valid && cmd_ready;
  // accept and apply are mutually exclusive: a command captured on a frame
  // boundary is not yet pending there, so it waits for the next boundary.
  assign apply     = pending && tick && frame_end;

  always_comb begin
    lit = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (mode[i])
        MODE_OFF:   lit[i] = 1'b0;
        MODE_ON:    lit[i] = 1'b1;
        MODE_PWM:   lit[i] = (pwm_cnt < level[i]);
        MODE_BLINK: lit[i] = blink_phase && (pwm_cnt < level[i]);
        default:    lit[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= 1'b0;
      pend_cmd <= '0;
      led      <= '1;
      for (int i = 0; i < NUM_LEDS; i++) begin
        mode[i]  <= MODE_OFF;
        level[i] <= '0;
      end
    end else begin
      if (accept) begin
        pending        <= 1'b1;
        pend_cmd.idx   <= cmd_data[IDX_LSB +: IDX_W];
        pend_cmd.mode  <= led_mode_e'(cmd_data[MODE_LSB +: MODE_W]);
        pend_cmd.level <= cmd_data[LVL_LSB +: LVL_W];
      end else if (apply) begin
        pending              <= 1'b0;
        mode[pend_cmd.idx]   <= pend_cmd.mode;
        level[pend_cmd.idx]  <= pend_cmd.level;
      end
      led <= ~lit;
    end
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl with CLK_DIV=4, BLINK_FRAMES=2 (64-cycle frames,
// blink phase flips every 128 cycles); expectations are written as functions of cycle number.
module tb_led_pwm_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready;
  logic [3:0] led;

  int cyc;
  int checks = 0;
  int errors = 0;

  led_pwm_ctrl #(
    .CLK_DIV      (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .led       (led)
  );

  always #5 clk = ~clk;

  // cyc == n after the n-th rising edge since reset release
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic send(input int n, input logic [7:0] data);
    goto(n);
    cmd_valid = 1'b1;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    #1;
    check("rst_led", led, 4'hf);
    check("rst_rdy", cmd_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // led pins at cycle n reflect state after edge n-1: p = n-1
  function automatic logic [3:0] exp_led(int n, bit on0, bit pwm1_4, bit blink2_15);
    int p;
    logic [3:0] e;
    p = n - 1;
    e = 4'hf;
    if (on0) e[0] = 1'b0;
    if (pwm1_4 && (p % 64) < 16) e[1] = 1'b0;
    if (blink2_15 && ((p / 128) % 2) == 1 && (p % 64) < 60) e[2] = 1'b0;
    return e;
  endfunction

  function automatic logic [3:0] exp_d_led(int n);
    logic [3:0] e;
    e = 4'hf;
    if (n >= 65)  e[3] = 1'b0;
    if (n >= 193) e[0] = 1'b0;
    return e;
  endfunction

  function automatic logic exp_d_rdy(int n);
    return !((n >= 11 && n < 64) || (n >= 128 && n < 192));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int lows1, lows2_on, lows2_off;

    // held in reset, then idle for 500 cycles
    repeat (2) @(negedge clk);
    check("hold_led", led, 4'hf);
    check("hold_rdy", cmd_ready, 1'b1);
    rst = 1'b0;
    for (int n = 1; n <= 500; n++) begin
      goto(n);
      check("idle_led", led, 4'hf);
      check("idle_rdy", cmd_ready, 1'b1);
    end

    // LED0 ON: applied on frame_end edge 64, pin follows one cycle later
    do_reset();
    send(10, 8'b00_01_0000);
    check("a_rdy_drop", cmd_ready, 1'b0);
    goto(63);
    check("a_rdy_63", cmd_ready, 1'b0);
    check("a_led_63", led, 4'hf);
    goto(64);
    check("a_rdy_64", cmd_ready, 1'b1);
    check("a_led_64", led, 4'hf);
    goto(65);
    check("a_led_65", led, 4'he);

    // LED1 PWM level 4 applied at edge 128
    send(70, 8'b01_10_0100);
    lows1 = 0;
    for (int n = 72; n <= 259; n++) begin
      goto(n);
      check("b_led", led, exp_led(n, 1'b1, n >= 129, 1'b0));
      check("b_rdy", cmd_ready, !(n >= 71 && n < 128));
      if (n >= 129 && n <= 256 && !led[1]) lows1++;
    end
    check("b_low_cnt", 8'(lows1), 8'd32);

    // LED2 BLINK level 15 applied at edge 320
    send(260, 8'b10_11_1111);
    lows2_on  = 0;
    lows2_off = 0;
    for (int n = 262; n <= 704; n++) begin
      goto(n);
      check("c_led", led, exp_led(n, 1'b1, 1'b1, n >= 321));
      check("c_rdy", cmd_ready, !(n >= 261 && n < 320));
      if (n >= 385 && n <= 512 && !led[2]) lows2_on++;
      if (((n >= 321 && n <= 384) || (n >= 513 && n <= 640)) && !led[2]) lows2_off++;
    end
    check("c_blink_on", 8'(lows2_on), 8'd120);
    check("c_blink_off", 8'(lows2_off), 8'd0);

    // second strobe while pending ignored; acceptance on frame_end waits a frame
    do_reset();
    send(10, 8'b11_01_0000);
    goto(20);
    cmd_valid = 1'b1;
    cmd_data  = 8'b11_10_1000;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int n = 21; n <= 126; n++) begin
      goto(n);
      check("d_led", led, exp_d_led(n));
      check("d_rdy", cmd_ready, exp_d_rdy(n));
    end
    goto(127);
    check("d_rdy_127", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_data  = 8'b00_01_0000;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int n = 128; n <= 200; n++) begin
      goto(n);
      check("d2_led", led, exp_d_led(n));
      check("d2_rdy", cmd_ready, exp_d_rdy(n));
    end

    // reset mid-frame with a command pending
    send(210, 8'b01_01_0000);
    check("e_rdy_pend", cmd_ready, 1'b0);
    goto(230);
    rst = 1'b1;
    #1;
    check("e_led_now", led, 4'hf);
    check("e_rdy_now", cmd_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      goto(n);
      check("e_led", led, 4'hf);
      check("e_rdy", cmd_ready, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
